alu_multicycle: RTL and testbench

//  Parametrised integer ALU with a valid/ready handshake. It adds iterative signed MUL/DIV (HI/LO

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_div_iter.sv | 103 ++++++++++
 rtl/alu_multicycle.sv | 202 ++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : op codes, FSM states and op classification for alu_multicycle.
//           Macro ALU_DIV_EN makes DIV a long (iterative) op.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRA  = 4'd1,
    ALU_SRL  = 4'd2,
    ALU_MUL  = 4'd3,
    ALU_DIV  = 4'd4,
    ALU_ADD  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_AND  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_XOR  = 4'd9,
    ALU_NOR  = 4'd10,
    ALU_CMP  = 4'd11,
    ALU_CMPU = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_long_op(input logic [3:0] op);
`ifdef ALU_DIV_EN
    return (op == ALU_MUL) || (op == ALU_DIV);
`else
    return (op == ALU_MUL);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_div_iter.sv
`default_nettype none
// ============================================================================
// alu_div_iter : signed restoring divider, one quotient bit per clock.
//                done marks the cycle in which quotient/remainder are final.
// Revision : 1.0
// ============================================================================
module alu_div_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  // The partial remainder stays below the divisor, so its MSB is free when the trial fails
  assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
  assign rem_step = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  assign done        = run_q && (cnt_q == CNT_LAST);
  assign quotient    = dbz_q ? {WIDTH{1'b1}} : (q_neg_q ? -quo_step : quo_step);
  assign remainder   = dbz_q ? dvd_q : (r_neg_q ? -rem_step : rem_step);
  assign div_by_zero = dbz_q;

  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dbz_d   = dbz_q;
    if (start) begin
      run_d   = 1'b1;
      cnt_d   = '0;
      quo_d   = dividend[WIDTH-1] ? -dividend : dividend;
      rem_d   = '0;
      dvs_d   = divisor[WIDTH-1] ? -divisor : divisor;
      dvd_d   = dividend;
      q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_d = dividend[WIDTH-1];
      dbz_d   = (divisor == '0);
    end else if (run_q) begin
      quo_d = quo_step;
      rem_d = rem_step;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// alu_multicycle : integer ALU with valid/ready handshake, iterative signed
//                  MUL and (with macro ALU_DIV_EN) iterative signed DIV.
// Revision : 1.0
// ============================================================================
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             equal,
  output logic             div_by_zero,
  output logic             illegal_op,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               equal_q, equal_d;
  logic               dbz_q, dbz_d;
  logic               ill_q, ill_d;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_next, prod_signed;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ill;

  // DONE also accepts so a consumed result and a new op share one edge
  assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q == MUL) || (state_q == DIV);
  assign out_lo      = lo_q;
  assign out_hi      = hi_q;
  assign equal       = equal_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

  assign shamt = in2[SHAMT_W-1:0];
  assign abs1  = in1[WIDTH-1] ? -in1 : in1;
  assign abs2  = in2[WIDTH-1] ? -in2 : in2;

  // Shift-add on magnitudes: the multiplier sits in the low half and is consumed LSB first
  assign mul_sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_next   = {mul_sum, prod_q[WIDTH-1:1]};
  assign prod_signed = neg_q ? -prod_next : prod_next;

`ifdef ALU_DIV_EN
  logic             div_done;
  logic             div_dbz;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  alu_div_iter #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (accept && (op == ALU_DIV)),
    .dividend    (in1),
    .divisor     (in2),
    .done        (div_done),
    .quotient    (div_quo),
    .remainder   (div_rem),
    .div_by_zero (div_dbz)
  );
`endif

  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    case (op)
      ALU_SLL:  sc_res = in1 << shamt;
      ALU_SRA:  sc_res = $signed(in1) >>> shamt;
      ALU_SRL:  sc_res = in1 >> shamt;
      ALU_ADD:  sc_res = in1 + in2;
      ALU_SUB:  sc_res = in1 - in2;
      ALU_AND:  sc_res = in1 & in2;
      ALU_OR:   sc_res = in1 | in2;
      ALU_XOR:  sc_res = in1 ^ in2;
      ALU_NOR:  sc_res = ~(in1 | in2);
      ALU_CMP:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      ALU_CMPU: sc_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
`ifdef ALU_DIV_EN
      ALU_MUL, ALU_DIV: sc_res = '0;
`else
      ALU_MUL:  sc_res = '0;
`endif
      default:  sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    neg_d   = neg_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    equal_d = equal_q;
    dbz_d   = dbz_q;
    ill_d   = ill_q;

    case (state_q)
      MUL: begin
        prod_d = prod_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d      = DONE;
          {hi_d, lo_d} = prod_signed;
        end
      end
`ifdef ALU_DIV_EN
      DIV: begin
        if (div_done) begin
          state_d = DONE;
          lo_d    = div_quo;
          hi_d    = div_rem;
          dbz_d   = div_dbz;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      equal_d = (in1 == in2);
      dbz_d   = 1'b0;
      ill_d   = 1'b0;
      cnt_d   = '0;
      if (op == ALU_MUL) begin
        state_d = MUL;
        mcand_d = abs1;
        prod_d  = {{WIDTH{1'b0}}, abs2};
        neg_d   = in1[WIDTH-1] ^ in2[WIDTH-1];
      end else if (is_long_op(op)) begin
        state_d = DIV;
      end else begin
        state_d = DONE;
        lo_d    = sc_res;
        hi_d    = '0;
        ill_d   = sc_ill;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      equal_q <= 1'b0;
      dbz_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      neg_q   <= neg_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      equal_q <= equal_d;
      dbz_q   <= dbz_d;
      ill_q   <= ill_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// tb_alu_multicycle : directed self-checking bench for alu_multicycle (WIDTH=32).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_alu_multicycle;

  localparam int W = 32;
  localparam logic [3:0] OP_SLL = 4'd0,  OP_SRA = 4'd1,  OP_SRL = 4'd2,  OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4,  OP_ADD = 4'd5,  OP_SUB = 4'd6,  OP_AND = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8,  OP_XOR = 4'd9,  OP_NOR = 4'd10, OP_CMP = 4'd11;
  localparam logic [3:0] OP_CMPU = 4'd12;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic         equal, div_by_zero, illegal_op, busy;
  logic [3:0]   op;
  logic [W-1:0] in1, in2, out_lo, out_hi;

  int n_checks = 0;
  int n_errors = 0;

  // Single-cycle vectors: op, in1, in2, expected out_lo
  logic [3:0]   t_op [0:11] = '{OP_SRA, OP_CMP, OP_CMPU, OP_SLL, OP_SRL, OP_SUB,
                                OP_AND, OP_OR, OP_XOR, OP_NOR, OP_CMP, 4'd13};
  logic [W-1:0] t_a  [0:11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,
                                32'h8000_0000, 32'h0000_0000, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                                32'hFFFF_0000, 32'h0000_0000, 32'h0000_0007, 32'h0000_0007};
  logic [W-1:0] t_b  [0:11] = '{32'h0000_0024, 32'h0000_0001, 32'h0000_0001, 32'h0000_003F,
                                32'h0000_0004, 32'h0000_0001, 32'h0FF0_0FF0, 32'h0F0F_0000,
                                32'h0F0F_0F0F, 32'h0000_0000, 32'h0000_0007, 32'h0000_0007};
  logic [W-1:0] t_e  [0:11] = '{32'hF800_0000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000,
                                32'h0800_0000, 32'hFFFF_FFFF, 32'h00F0_00F0, 32'hFFFF_F0F0,
                                32'hF0F0_0F0F, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .in1         (in1),
    .in2         (in2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_lo      (out_lo),
    .out_hi      (out_hi),
    .equal       (equal),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op),
    .busy        (busy)
  );

  // Present one op for a single edge; it must be accepted at that edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; in1 = a; in2 = b; in_valid = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL accept op=%0d: in_ready=%b required 1", o, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, equal, div_by_zero, illegal_op} !== 6'b100000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b required 100000",
               {in_ready, out_valid, busy, equal, div_by_zero, illegal_op});
    end
    n_checks++;
    if ({out_hi, out_lo} !== 64'h0) begin
      n_errors++;
      $display("FAIL reset_data: got %h required 0", {out_hi, out_lo});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL add_pre_valid: out_valid=%b required 0", out_valid);
    end
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    n_checks++;
    if ({out_valid, out_hi, out_lo} !== {1'b1, 64'h0}) begin
      n_errors++;
      $display("FAIL add_wrap: valid=%b hi_lo=%h required valid=1 hi_lo=0",
               out_valid, {out_hi, out_lo});
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL add_consumed: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_single_cycle;
    logic exp_ill, exp_eq;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_ill = (t_op[i] >= 4'd13);
      exp_eq  = (t_a[i] == t_b[i]);
      issue(t_op[i], t_a[i], t_b[i]);
      n_checks++;
      if ({out_valid, illegal_op, equal, out_hi, out_lo} !==
          {1'b1, exp_ill, exp_eq, 32'h0, t_e[i]}) begin
        n_errors++;
        $display("FAIL single[%0d] op=%0d: v/ill/eq=%b%b%b hi=%h lo=%h required %b%b%b hi=0 lo=%h",
                 i, t_op[i], out_valid, illegal_op, equal, out_hi, out_lo,
                 1'b1, exp_ill, exp_eq, t_e[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [2*W-1:0] exp);
    int n, nb;
    out_ready = 1'b0;
    issue(OP_MUL, a, b);
    // Changing operands with in_valid high must not disturb the running op
    op = OP_ADD; in1 = '1; in2 = '1; in_valid = 1'b1;
    n = 1; nb = 0;
    while (!out_valid && n < 100) begin
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (n !== 33 || nb !== 32) begin
      n_errors++;
      $display("FAIL mul_latency %h*%h: latency=%0d busy=%0d required 33/32", a, b, n, nb);
    end
    n_checks++;
    if ({busy, out_hi, out_lo} !== {1'b0, exp}) begin
      n_errors++;
      $display("FAIL mul %h*%h: busy=%b got %h required %h", a, b, busy, {out_hi, out_lo}, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_mul;
    test_mul_vec(32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);
    test_mul_vec(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    test_mul_vec(32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    test_mul_vec(32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780);
    test_mul_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
  endtask

`ifdef ALU_DIV_EN
  task automatic test_div_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi,
                              input logic exp_dbz);
    int n;
    out_ready = 1'b0;
    issue(OP_DIV, a, b);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (n !== 33) begin
      n_errors++;
      $display("FAIL div_latency %h/%h: latency=%0d required 33", a, b, n);
    end
    n_checks++;
    if ({div_by_zero, illegal_op, out_hi, out_lo} !== {exp_dbz, 1'b0, exp_hi, exp_lo}) begin
      n_errors++;
      $display("FAIL div %h/%h: dbz=%b ill=%b hi=%h lo=%h required dbz=%b ill=0 hi=%h lo=%h",
               a, b, div_by_zero, illegal_op, out_hi, out_lo, exp_dbz, exp_hi, exp_lo);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_div;
    test_div_vec(32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    test_div_vec(32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005, 1'b1);
    test_div_vec(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
    test_div_vec(32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b0);
    test_div_vec(32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002, 1'b0);
  endtask
`else
  task automatic test_div;
    out_ready = 1'b1;
    issue(OP_DIV, 32'h0000_0005, 32'h0000_0002);
    n_checks++;
    if ({out_valid, illegal_op, div_by_zero, out_hi, out_lo} !== {3'b110, 64'h0}) begin
      n_errors++;
      $display("FAIL div_disabled: v/ill/dbz=%b%b%b hi_lo=%h required 110 hi_lo=0",
               out_valid, illegal_op, div_by_zero, {out_hi, out_lo});
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_back_to_back;
    int results;
    out_ready = 1'b0;
    issue(OP_ADD, 32'd3, 32'd4);
    op = OP_SUB; in1 = 32'h5555_5555; in2 = 32'h1111_1111; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, in_ready, out_hi, out_lo} !== {2'b10, 32'h0, 32'd7}) begin
        n_errors++;
        $display("FAIL hold[%0d]: v/rdy=%b%b hi=%h lo=%h required 10 hi=0 lo=7",
                 i, out_valid, in_ready, out_hi, out_lo);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    op = OP_ADD;
    results = 0;
    for (int i = 0; i < 10; i++) begin
      in1 = 32'(i); in2 = 32'h100; in_valid = 1'b1;
      @(posedge clk); #1;
      if (out_valid === 1'b1 && out_lo === 32'(i + 256)) results++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (results !== 10) begin
      n_errors++;
      $display("FAIL back_to_back: %0d correct results required 10", results);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_drain: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int stale;
    out_ready = 1'b1;
    issue(OP_MUL, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy, equal, div_by_zero, illegal_op, out_hi, out_lo} !==
        {6'b100000, 64'h0}) begin
      n_errors++;
      $display("FAIL reset_mid: rdy/v/busy=%b%b%b hi_lo=%h required 100 hi_lo=0",
               in_ready, out_valid, busy, {out_hi, out_lo});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale++;
    end
    n_checks++;
    if (stale !== 0) begin
      n_errors++;
      $display("FAIL reset_mid_stale: out_valid high %0d cycles required 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_cycle();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
